collision_sequencer: RTL
========================

COLLISION_SEQUENCER -- requirements
Module: collision_sequencer

Interface
REQ-001 Parameter SEGS, default 10, maximum segments per snake.
REQ-002 Parameter MAX_LEN, default 16, bit pitch of one segment slot in a snake vector.
REQ-003 Parameter NUM_LEN, default 10, coordinate bits per segment, at bits [i*MAX_LEN +: NUM_LEN]; segment 0 = head.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level; leaves IDLE or OVER into RUN.
REQ-007 tick  in  1  one-cycle move pulse requesting a collision evaluation.
REQ-008 snake1, snake2  in  SEGS*MAX_LEN each  packed segment vectors.
REQ-009 len1, len2  in  4 each  active segment counts.
REQ-010 busy  out  1  high in SCAN and RESOLVE.
REQ-011 done  out  1  one-cycle pulse when an evaluation completes.
REQ-012 should_stop1, should_stop2  out  1 each  snake head collided, sticky until start or rst.
REQ-013 game_over  out  1  sticky, high in OVER.
REQ-014 winner  out  2  01 snake1 wins, 10 snake2 wins, 11 draw, 00 undecided.
REQ-015 overrun  out  1  sticky; a tick arrived while busy.

Function
REQ-016 FSM states IDLE, RUN, SCAN, RESOLVE, OVER; IDLE->RUN on start; RUN->SCAN on tick; SCAN->RESOLVE after L scan cycles; RESOLVE->OVER if any hit, else RESOLVE->RUN; OVER->RUN on start.
REQ-017 On the RUN edge accepting tick, snake1, snake2, len1, len2 shall be snapshotted; later input changes shall not affect that evaluation.
REQ-018 Effective length shall be clamped: 0 -> 1, >SEGS -> SEGS; L = max(eff len1, eff len2).
REQ-019 SCAN processes index k = 0..L-1, one index per cycle, with a counter wide enough for SEGS.
REQ-020 At index k, hit1 accumulates if head1 == snake2 seg k with k < len2, or head1 == snake1 seg k with 1 <= k < len1.
REQ-021 hit2 shall be computed symmetrically; hit1/hit2 are cleared on SCAN entry.
REQ-022 Head-to-head equality (k=0 cross compare) shall set both hit1 and hit2.
REQ-023 In RESOLVE, should_stop1 <= hit1 and should_stop2 <= hit2; winner <= {hit1,hit2} mapped as 10->10, 01->01, 11->11, 00->00; game_over <= hit1|hit2.
REQ-024 done shall be high for exactly one cycle, the cycle after the RESOLVE edge, so done rises L+2 cycles after the tick-sampling edge.
REQ-025 A tick while in SCAN or RESOLVE shall be dropped and set overrun; a tick in IDLE or OVER shall be ignored without setting overrun.
REQ-026 start while in RUN, SCAN or RESOLVE shall have no effect.
REQ-027 start in OVER shall clear should_stop1/2, winner, game_over and overrun, and enter RUN the same edge.
REQ-028 A tick coincident with start in OVER shall be ignored.

Reset
REQ-029 rst high shall immediately force IDLE, clear the scan counter and hit flags, and drive busy, done, should_stop1, should_stop2, game_over, overrun to 0 and winner to 00.
REQ-030 rst asserted mid-SCAN shall abort the evaluation with no done pulse.
REQ-031 Release of rst shall not itself start the FSM; start is required.

Verification
REQ-032 Disjoint snakes, len1=len2=3, one tick -> busy 4 cycles, done at tick+5, stops 0, winner 00, state RUN.
REQ-033 head1 equals snake2 seg 2, len2=3 -> should_stop1=1, should_stop2=0, winner 10, game_over=1.
REQ-034 Both heads equal coordinate 10'h155 -> both stops 1, winner 11; then start -> all flags 0, state RUN.
REQ-035 head2 equals snake2 seg 1, len2=2 -> should_stop2=1, winner 01; same case with len2=1 -> no hit.
REQ-036 len1=0, len2=15 -> L=10, done at tick+12; a second tick 3 cycles after the first -> overrun=1, only one done.
REQ-037 rst pulsed during SCAN cycle 2 -> all outputs 0 at once, no done, ticks ignored until start.

Source files
------------

// File: rtl/collision_sequencer.sv
// Two-snake collision evaluator: snapshots both snakes on a tick, walks segment
// indices one per cycle, then latches per-snake stop flags, winner and game-over.
module collision_sequencer #(
    parameter int SEGS    = 10,
    parameter int MAX_LEN = 16,
    parameter int NUM_LEN = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    tick,
    input  logic [SEGS*MAX_LEN-1:0] snake1,
    input  logic [SEGS*MAX_LEN-1:0] snake2,
    input  logic [3:0]              len1,
    input  logic [3:0]              len2,
    output logic                    busy,
    output logic                    done,
    output logic                    should_stop1,
    output logic                    should_stop2,
    output logic                    game_over,
    output logic [1:0]              winner,
    output logic                    overrun
);

    localparam int CW = $clog2(SEGS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_RESOLVE,
        S_OVER
    } state_t;

    typedef logic [NUM_LEN-1:0] coord_t;

    state_t          state_q, state_d;
    logic   [CW-1:0] cnt_q, cnt_d;
    logic   [CW-1:0] len1_q, len1_d;
    logic   [CW-1:0] len2_q, len2_d;
    logic   [CW-1:0] lmax_q, lmax_d;
    logic            hit1_q, hit1_d;
    logic            hit2_q, hit2_d;
    logic            stop1_q, stop1_d;
    logic            stop2_q, stop2_d;
    logic            over_q, over_d;
    logic   [1:0]    winner_q, winner_d;
    logic            overrun_q, overrun_d;
    logic            done_pend_q, done_pend_d;
    logic            done_q, done_d;
    coord_t          seg1_q [SEGS];
    coord_t          seg1_d [SEGS];
    coord_t          seg2_q [SEGS];
    coord_t          seg2_d [SEGS];

    coord_t          in1 [SEGS];
    coord_t          in2 [SEGS];
    coord_t          cur1, cur2;
    logic            idx_hit1, idx_hit2;
    logic   [CW-1:0] eff1, eff2;

    // Only the low NUM_LEN bits of each segment slot carry a coordinate.
    for (genvar g = 0; g < SEGS; g++) begin : g_unpack
        assign in1[g] = snake1[g*MAX_LEN +: NUM_LEN];
        assign in2[g] = snake2[g*MAX_LEN +: NUM_LEN];
        if (MAX_LEN > NUM_LEN) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{snake1[g*MAX_LEN+NUM_LEN +: MAX_LEN-NUM_LEN],
                                  snake2[g*MAX_LEN+NUM_LEN +: MAX_LEN-NUM_LEN]};
        end
    end

    function automatic logic [CW-1:0] clamp_len(input logic [3:0] l);
        if (l == 4'd0)
            return CW'(1);
        else if (int'(l) > SEGS)
            return CW'(SEGS);
        else
            return CW'(l);
    endfunction

    assign eff1 = clamp_len(len1);
    assign eff2 = clamp_len(len2);

    // Per-index compare; k=0 cross compare makes a head-on collision hit both.
    always_comb begin
        cur1 = '0;
        cur2 = '0;
        for (int i = 0; i < SEGS; i++) begin
            if (cnt_q == CW'(i)) begin
                cur1 = seg1_q[i];
                cur2 = seg2_q[i];
            end
        end
        idx_hit1 = ((seg1_q[0] == cur2) && (cnt_q < len2_q)) ||
                   ((seg1_q[0] == cur1) && (cnt_q != '0) && (cnt_q < len1_q));
        idx_hit2 = ((seg2_q[0] == cur1) && (cnt_q < len1_q)) ||
                   ((seg2_q[0] == cur2) && (cnt_q != '0) && (cnt_q < len2_q));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len1_d      = len1_q;
        len2_d      = len2_q;
        lmax_d      = lmax_q;
        hit1_d      = hit1_q;
        hit2_d      = hit2_q;
        stop1_d     = stop1_q;
        stop2_d     = stop2_q;
        over_d      = over_q;
        winner_d    = winner_q;
        overrun_d   = overrun_q;
        done_pend_d = 1'b0;
        done_d      = done_pend_q;
        seg1_d      = seg1_q;
        seg2_d      = seg2_q;

        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (tick) begin
                    state_d = S_SCAN;
                    seg1_d  = in1;
                    seg2_d  = in2;
                    len1_d  = eff1;
                    len2_d  = eff2;
                    lmax_d  = (eff1 > eff2) ? eff1 : eff2;
                    cnt_d   = '0;
                    hit1_d  = 1'b0;
                    hit2_d  = 1'b0;
                end
            end
            S_SCAN: begin
                hit1_d = hit1_q | idx_hit1;
                hit2_d = hit2_q | idx_hit2;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == lmax_q - CW'(1))
                    state_d = S_RESOLVE;
                if (tick)
                    overrun_d = 1'b1;
            end
            S_RESOLVE: begin
                stop1_d     = hit1_q;
                stop2_d     = hit2_q;
                winner_d    = {hit1_q, hit2_q};
                over_d      = hit1_q | hit2_q;
                done_pend_d = 1'b1;
                state_d     = (hit1_q | hit2_q) ? S_OVER : S_RUN;
                if (tick)
                    overrun_d = 1'b1;
            end
            S_OVER: begin
                // A tick in the same cycle as start is deliberately not sampled.
                if (start) begin
                    state_d   = S_RUN;
                    stop1_d   = 1'b0;
                    stop2_d   = 1'b0;
                    winner_d  = 2'b00;
                    over_d    = 1'b0;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len1_q      <= '0;
            len2_q      <= '0;
            lmax_q      <= '0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            stop1_q     <= 1'b0;
            stop2_q     <= 1'b0;
            over_q      <= 1'b0;
            winner_q    <= 2'b00;
            overrun_q   <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < SEGS; i++) begin
                seg1_q[i] <= '0;
                seg2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len1_q      <= len1_d;
            len2_q      <= len2_d;
            lmax_q      <= lmax_d;
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            stop1_q     <= stop1_d;
            stop2_q     <= stop2_d;
            over_q      <= over_d;
            winner_q    <= winner_d;
            overrun_q   <= overrun_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_d;
            seg1_q      <= seg1_d;
            seg2_q      <= seg2_d;
        end
    end

    assign busy         = (state_q == S_SCAN) || (state_q == S_RESOLVE);
    assign done         = done_q;
    assign should_stop1 = stop1_q;
    assign should_stop2 = stop2_q;
    assign game_over    = over_q;
    assign winner       = winner_q;
    assign overrun      = overrun_q;

endmodule
